fp_unpack: RTL

Registered operand unpack stage that sits directly downstream of the combinational special-value classifier (`fp_special`) and upstream of the FPU arithmetic cores. It accepts one IEEE-754 operand per start handshake and classifies it. It then emits a sign, an unbiased signed exponent and a mantissa with an explicit leading one. Subnormal operands are normalized iteratively, one left shift per cycle, so the arithmetic cores only ever see normalized operands plus special-value flags.

---
 rtl/fp_pkg.sv | 37 +++
 rtl/fp_special.sv | 44 ++++
 rtl/fp_unpack.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared constants, derivations and the FSM state type for the
// floating-point operand unpack path.
//   - DATA_W_DEF / EXP_W_DEF : default operand and exponent-field widths
//   - man_w()                : mantissa width including the hidden bit
//   - bias()                 : IEEE-754 exponent bias for a field width
//   - xexp_w()               : width of the unbiased signed exponent
//   - unpack_state_t         : IDLE / NORM / DONE
package fp_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int EXP_W_DEF  = 8;

  function automatic int man_w(input int data_w, input int exp_w);
    return data_w - exp_w;
  endfunction

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Two guard bits cover both the most negative subnormal exponent and the
  // Inf/NaN exponent without wrapping.
  function automatic int xexp_w(input int exp_w);
    return exp_w + 2;
  endfunction

  localparam int MAN_W_DEF  = man_w(DATA_W_DEF, EXP_W_DEF);
  localparam int BIAS_DEF   = bias(EXP_W_DEF);
  localparam int XEXP_W_DEF = xexp_w(EXP_W_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } unpack_state_t;

endpackage

// File: rtl/fp_special.sv
// fp_special: combinational IEEE-754 special-value classifier.
// Ports:
//   data_in    : operand
//   sign       : sign bit
//   nan        : exponent all ones, fraction non-zero
//   infinite   : exponent all ones, fraction zero
//   zero       : exponent zero, fraction zero (either sign)
//   sub_normal : exponent zero, fraction non-zero
module fp_special
  import fp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int EXP_W  = EXP_W_DEF
) (
  input  logic [DATA_W-1:0] data_in,
  output logic              sign,
  output logic              nan,
  output logic              infinite,
  output logic              zero,
  output logic              sub_normal
);

  localparam int FRAC_W = man_w(DATA_W, EXP_W) - 1;

  logic [EXP_W-1:0]  exp_field;
  logic [FRAC_W-1:0] frac_field;
  logic              exp_max;
  logic              exp_min;
  logic              frac_nz;

  assign sign       = data_in[DATA_W-1];
  assign exp_field  = data_in[DATA_W-2 -: EXP_W];
  assign frac_field = data_in[FRAC_W-1:0];

  assign exp_max = &exp_field;
  assign exp_min = ~|exp_field;
  assign frac_nz = |frac_field;

  assign nan        = exp_max &  frac_nz;
  assign infinite   = exp_max & ~frac_nz;
  assign zero       = exp_min & ~frac_nz;
  assign sub_normal = exp_min &  frac_nz;

endmodule

// File: rtl/fp_unpack.sv
// fp_unpack: registered operand unpack stage. Accepts one IEEE-754 operand
// per start handshake, registers its class flags and produces sign, unbiased
// signed exponent and a mantissa with an explicit leading one. Subnormals are
// normalized one left shift per cycle.
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   start        : request, accepted when busy is low
//   data_in      : operand, sampled on the accept edge only
//   busy         : high while normalizing (start ignored)
//   done         : one-cycle pulse, result valid from this cycle on
//   sign_o       : operand sign
//   exp_o        : signed unbiased exponent, EXP_W+2 bits
//   man_o        : mantissa, MSB is the explicit leading one
//   nan, infinite, zero, sub_normal : registered class of the operand
module fp_unpack
  import fp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int EXP_W  = EXP_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [DATA_W-1:0]           data_in,
  output logic                        busy,
  output logic                        done,
  output logic                        sign_o,
  output logic signed [EXP_W+1:0]     exp_o,
  output logic [DATA_W-EXP_W-1:0]     man_o,
  output logic                        nan,
  output logic                        infinite,
  output logic                        zero,
  output logic                        sub_normal
);

  localparam int MAN_W  = man_w(DATA_W, EXP_W);
  localparam int FRAC_W = MAN_W - 1;
  localparam int XW     = xexp_w(EXP_W);

  localparam logic [XW-1:0] BIAS_X = XW'(bias(EXP_W));
  localparam logic [XW-1:0] ONE_X  = XW'(1);

  unpack_state_t state_reg;

  logic              cls_sign;
  logic              cls_nan;
  logic              cls_inf;
  logic              cls_zero;
  logic              cls_sub;
  logic [EXP_W-1:0]  exp_field;
  logic [FRAC_W-1:0] frac_field;
  logic              accept;

  fp_special #(
    .DATA_W (DATA_W),
    .EXP_W  (EXP_W)
  ) u_special (
    .data_in    (data_in),
    .sign       (cls_sign),
    .nan        (cls_nan),
    .infinite   (cls_inf),
    .zero       (cls_zero),
    .sub_normal (cls_sub)
  );

  assign exp_field  = data_in[DATA_W-2 -: EXP_W];
  assign frac_field = data_in[FRAC_W-1:0];

  // A DONE-cycle accept overlaps the pulse, giving one operand per cycle.
  assign accept = start && (state_reg != NORM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      sign_o     <= 1'b0;
      exp_o      <= '0;
      man_o      <= '0;
      nan        <= 1'b0;
      infinite   <= 1'b0;
      zero       <= 1'b0;
      sub_normal <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= 1'b0;
      if (accept) begin
        sign_o     <= cls_sign;
        nan        <= cls_nan;
        infinite   <= cls_inf;
        zero       <= cls_zero;
        sub_normal <= cls_sub;
        if (cls_sub) begin
          // Start at the minimum normal exponent with the hidden bit clear;
          // the NORM loop shifts the leading one up into the MSB.
          exp_o     <= ONE_X - BIAS_X;
          man_o     <= {1'b0, frac_field};
          state_reg <= NORM;
          busy      <= 1'b1;
        end else begin
          state_reg <= DONE;
          done      <= 1'b1;
          if (cls_zero) begin
            exp_o <= '0;
            man_o <= '0;
          end else if (cls_nan || cls_inf) begin
            exp_o <= BIAS_X + ONE_X;
            man_o <= {1'b1, frac_field};
          end else begin
            exp_o <= {2'b00, exp_field} - BIAS_X;
            man_o <= {1'b1, frac_field};
          end
        end
      end else begin
        case (state_reg)
          NORM: begin
            man_o <= man_o << 1;
            exp_o <= exp_o - ONE_X;
            // The bit just below the MSB becomes the MSB after this shift.
            if (man_o[MAN_W-2]) begin
              state_reg <= DONE;
              done      <= 1'b1;
            end else begin
              busy <= 1'b1;
            end
          end
          DONE:    state_reg <= IDLE;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule
